serial_bit_tx: RTL and testbench

//  Parallel-in, serial-out frame transmitter. It is the sending end of the single-wire bit

---
 rtl/serial_bit_tx_if.sv | 11 +
 rtl/serial_bit_tx.sv | 83 ++++++++
 tb/tb_serial_bit_tx.sv | 113 +++++++++++
 3 files changed

// File: rtl/serial_bit_tx_if.sv
// serial_bit_tx_if: word handshake and serial-line status bundle for serial_bit_tx
interface serial_bit_tx_if #(parameter int DATA_W = 8);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              tx_out;
  logic              tx_busy;
  logic              tx_done;
  modport master (output tx_valid, tx_data, input tx_ready, tx_out, tx_busy, tx_done);
  modport slave  (input tx_valid, tx_data, output tx_ready, tx_out, tx_busy, tx_done);
endinterface

// File: rtl/serial_bit_tx.sv
// serial_bit_tx: parallel-in serial-out framer (start, LSB-first data, optional even parity, stop)
module serial_bit_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input logic          clk,
  input logic          clear,
  serial_bit_tx_if.slave bus
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_W + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              out_q, out_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              last;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    last    = cnt_q == CW'(CLKS_PER_BIT - 1);
    if (state_q != IDLE) cnt_d = last ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: if (bus.tx_valid && ready_q) begin
        state_d = START;
        cnt_d   = '0;
        bit_d   = '0;
        shift_d = bus.tx_data;
        par_d   = ^bus.tx_data;
      end
      START: if (last) state_d = DATA;
      DATA: if (last) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 1'b1;
        if (bit_q == BW'(DATA_W - 1)) state_d = PARITY_EN != 0 ? PARITY : STOP;
      end
      PARITY: if (last) state_d = STOP;
      STOP: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // outputs are registered, so they are decoded from the next state
    out_d   = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
    ready_d = state_d == IDLE;
    busy_d  = !ready_d;
    done_d  = state_d == STOP && cnt_d == CW'(CLKS_PER_BIT - 1);
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      out_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign bus.tx_ready = ready_q;
  assign bus.tx_out   = out_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_done  = done_q;
endmodule

// File: tb/tb_serial_bit_tx.sv
// tb_serial_bit_tx: directed frame checks on three configurations of serial_bit_tx
module tb_serial_bit_tx;
  logic clk = 1'b0;
  logic clear = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  always #5 clk = ~clk;
  serial_bit_tx_if #(.DATA_W(8)) if_a ();
  serial_bit_tx_if #(.DATA_W(8)) if_b ();
  serial_bit_tx_if #(.DATA_W(4)) if_c ();
  serial_bit_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (.clk(clk), .clear(clear), .bus(if_a));
  serial_bit_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut_b (.clk(clk), .clear(clear), .bus(if_b));
  serial_bit_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut_c (.clk(clk), .clear(clear), .bus(if_c));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic set_in(input int sel, input logic v, input logic [15:0] d);
    case (sel)
      0: begin if_a.tx_valid = v; if_a.tx_data = d[7:0]; end
      1: begin if_b.tx_valid = v; if_b.tx_data = d[7:0]; end
      default: begin if_c.tx_valid = v; if_c.tx_data = d[3:0]; end
    endcase
  endtask
  // {out, done, ready, busy}
  function automatic logic [3:0] st(input int sel);
    case (sel)
      0: return {if_a.tx_out, if_a.tx_done, if_a.tx_ready, if_a.tx_busy};
      1: return {if_b.tx_out, if_b.tx_done, if_b.tx_ready, if_b.tx_busy};
      default: return {if_c.tx_out, if_c.tx_done, if_c.tx_ready, if_c.tx_busy};
    endcase
  endfunction
  task automatic chk_idle(input int sel, input string tag);
    logic [3:0] s;
    s = st(sel);
    chk({tag, ".out"}, s[3], 1'b1);
    chk({tag, ".done"}, s[2], 1'b0);
    chk({tag, ".ready"}, s[1], 1'b1);
    chk({tag, ".busy"}, s[0], 1'b0);
  endtask
  // frame holds the expected line bits in time order, bit 0 = start bit
  task automatic send(input int sel, input logic [15:0] d, input logic [15:0] frame, input int nbits,
                      input int cpb, input bit keep, input logic [15:0] nxt, input string tag);
    logic [3:0] s;
    set_in(sel, 1'b1, d);
    tick();
    set_in(sel, keep, nxt);
    s = st(sel);
    chk({tag, ".ready_low"}, s[1], 1'b0);
    chk({tag, ".busy_high"}, s[0], 1'b1);
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < cpb; c++) begin
        s = st(sel);
        chk($sformatf("%s.bit%0d.clk%0d", tag, i, c), s[3], frame[i]);
        chk($sformatf("%s.done%0d.%0d", tag, i, c), s[2], i == nbits - 1 && c == cpb - 1);
        if (!(i == nbits - 1 && c == cpb - 1)) tick();
      end
    end
    tick();
    chk_idle(sel, {tag, ".after"});
  endtask
  initial begin
    logic [3:0] s;
    set_in(0, 1'b1, 16'h00FF);
    set_in(1, 1'b1, 16'h00FF);
    set_in(2, 1'b1, 16'h000F);
    clear = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_idle(0, "rst_a");
      chk_idle(1, "rst_b");
      chk_idle(2, "rst_c");
    end
    clear = 1'b0;
    set_in(0, 1'b0, 16'h0);
    set_in(1, 1'b0, 16'h0);
    set_in(2, 1'b0, 16'h0);
    tick();
    chk_idle(0, "post_rst_a");
    send(0, 16'h00A5, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4, 1'b0, 16'h00FF, "a5");
    send(0, 16'h0007, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 4, 1'b0, 16'h0000, "p07");
    send(0, 16'h0000, {5'b0, 1'b1, 1'b0, 8'h00, 1'b0}, 11, 4, 1'b0, 16'h0000, "p00");
    send(0, 16'h003C, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 4, 1'b1, 16'h00C3, "b2b_3c");
    send(0, 16'h00C3, {5'b0, 1'b1, 1'b0, 8'hC3, 1'b0}, 11, 4, 1'b0, 16'h0000, "b2b_c3");
    set_in(0, 1'b1, 16'h0000);
    tick();
    set_in(0, 1'b0, 16'h0000);
    for (int k = 0; k < 15; k++) tick();
    s = st(0);
    chk("abort.pre_out", s[3], 1'b0);
    chk("abort.pre_busy", s[0], 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_idle(0, "abort.cut");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_idle(0, "abort.quiet");
    end
    send(0, 16'h005A, {5'b0, 1'b1, 1'b0, 8'h5A, 1'b0}, 11, 4, 1'b0, 16'h0000, "post_abort_5a");
    send(1, 16'h0007, {6'b0, 1'b1, 8'h07, 1'b0}, 10, 4, 1'b0, 16'h0000, "nopar07");
    send(2, 16'h0009, {9'b0, 1'b1, 1'b0, 4'h9, 1'b0}, 7, 1, 1'b0, 16'h0000, "cpb1_9");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
